// File: rtl/div_pkg.sv
// div_pkg: shared widths, status codes and FSM encoding for the divider operand sequencer
package div_pkg;
  localparam int L_DIVN_DEF = 8;
  localparam int L_DIVR_DEF = 4;
  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DIVZ     = 2'b01,
    ST_CORE_ERR = 2'b10,
    ST_TIMEOUT  = 2'b11
  } status_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESULT,
    S_FAULT
  } state_t;
endpackage

// File: rtl/div_operand_fifo.sv
// div_operand_fifo: power-of-two operand FIFO with registered pointers and a show-ahead head
module div_operand_fifo #(
  parameter int W  = 12,
  parameter int AW = 2
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt[AW];
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointers wrap naturally at the depth; occupancy tracks push minus pop
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer: queues operand pairs and sequences them through an external divider core
module div_operand_sequencer
  import div_pkg::*;
#(
  parameter int L_divn     = L_DIVN_DEF,
  parameter int L_divr     = L_DIVR_DEF,
  parameter int FIFO_AW    = 2,
  parameter int WAIT_LIMIT = 64
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [L_divn-1:0] in_dividend,
  input  logic [L_divr-1:0] in_divisor,
  output logic [L_divn-1:0] div_word1,
  output logic [L_divr-1:0] div_word2,
  output logic              div_start,
  input  logic              div_ready,
  input  logic              div_error,
  input  logic [L_divn-1:0] div_quotient,
  input  logic [L_divr-1:0] div_remainder,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [L_divn-1:0] out_quotient,
  output logic [L_divr-1:0] out_remainder,
  output logic [1:0]        out_status
);
  localparam int W  = L_divn + L_divr;
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [W-1:0] head;
  logic [L_divn-1:0] head_n, ld_q;
  logic [L_divr-1:0] head_r, ld_r;
  logic empty, full, pop, ld, ack, shown;
  status_t ld_s;
  state_t state, nstate;
  logic [CW-1:0] wait_cnt;
  assign head_n = head[W-1:L_divr];
  assign head_r = head[L_divr-1:0];
  assign in_ready = !full;
  assign ack = out_valid && out_ready;
  div_operand_fifo #(.W(W), .AW(FIFO_AW)) u_fifo (
    .clock  (clock),
    .reset_b(reset_b),
    .push   (in_valid),
    .pop    (pop),
    .wdata  ({in_dividend, in_divisor}),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );
  // state register
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) state <= S_IDLE;
    else state <= nstate;
  // next state, pop/start strobes and the result to load
  always_comb begin
    nstate = state;
    pop = 1'b0;
    div_start = 1'b0;
    ld = 1'b0;
    ld_q = '0;
    ld_r = '0;
    ld_s = ST_OK;
    case (state)
      S_IDLE:
        if (!empty && !out_valid) begin
          pop = 1'b1;
          ld = head_r == '0 || head_n == '0;
          ld_s = head_r == '0 ? ST_DIVZ : ST_OK;
          nstate = ld ? S_RESULT : S_ISSUE;
        end
      S_ISSUE:
        if (div_ready) begin
          div_start = 1'b1;
          nstate = S_WAIT_BUSY;
        end
      S_WAIT_BUSY, S_WAIT_DONE:
        if (div_error) begin
          ld = 1'b1;
          ld_s = ST_CORE_ERR;
          nstate = S_FAULT;
        end else if (div_ready && (state == S_WAIT_DONE || wait_cnt == CW'(1))) begin
          ld = 1'b1;
          ld_q = div_quotient;
          ld_r = div_remainder;
          nstate = S_RESULT;
        end else if (wait_cnt == CW'(WAIT_LIMIT)) begin
          ld = 1'b1;
          ld_s = ST_TIMEOUT;
          nstate = S_FAULT;
        end else if (state == S_WAIT_BUSY && !div_ready) nstate = S_WAIT_DONE;
      S_RESULT:
        if (ack) nstate = S_IDLE;
      default: nstate = state;
    endcase
  end
  // operand words, wait counter, result registers and the one-shot fault presentation
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      div_word1 <= '0;
      div_word2 <= '0;
      wait_cnt <= '0;
      out_quotient <= '0;
      out_remainder <= '0;
      out_status <= ST_OK;
      out_valid <= 1'b0;
      shown <= 1'b0;
    end else begin
      if (pop) begin
        div_word1 <= head_n;
        div_word2 <= head_r;
      end
      wait_cnt <= div_start ? '0 : (state == S_WAIT_BUSY || state == S_WAIT_DONE) ? wait_cnt + CW'(1) : wait_cnt;
      if (ld) begin
        out_quotient <= ld_q;
        out_remainder <= ld_r;
        out_status <= ld_s;
      end
      out_valid <= !ack && (state == S_RESULT || (state == S_FAULT && !shown));
      shown <= shown || (state == S_FAULT && ack);
    end
endmodule
